// File: rtl/writeback_arbiter.sv
// -----------------------------------------------------------------------------
// writeback_arbiter
//
// Collects finished results from N_PORTS functional-unit ports, picks one per
// cycle in round-robin order, and drives it through a single registered stage
// onto the regbank write port and the issue-logic wakeup broadcast.
//
// The regbank always accepts, so there is never backpressure: at most one port
// is granted per cycle and the grant is purely a function of the valids and the
// round-robin pointer.
//
// Tag 0 is the null destination: such results are accepted (and advance the
// pointer) but never produce a write or a wakeup. A flush accepts the transfer
// of the same cycle but discards it at the output stage.
//
// Optional build: define WB_STALL_CNT_EN to add per-port stall counters
// (stall_count_o) and a total accepted-transfer counter (grant_count_o).
// -----------------------------------------------------------------------------
module writeback_arbiter #(
  parameter int N_PORTS = 4,
  parameter int DWIDTH  = 32,
  parameter int AWIDTH  = 7
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flush,
  input  logic [N_PORTS-1:0][DWIDTH-1:0]  result_data_i,
  input  logic [N_PORTS-1:0][AWIDTH-1:0]  result_tag_i,
  input  logic [N_PORTS-1:0]              result_valid_i,
  output logic [N_PORTS-1:0]              result_ready_o,
  output logic [DWIDTH-1:0]               write_data,
  output logic [AWIDTH-1:0]               write_address,
  output logic                            wakeup_valid_o,
  output logic [AWIDTH-1:0]               wakeup_tag_o
`ifdef WB_STALL_CNT_EN
  ,
  output logic [N_PORTS-1:0][15:0]        stall_count_o,
  output logic [31:0]                     grant_count_o
`endif
);

  // Pointer width; the scan index carries one extra bit so ptr + offset never
  // overflows before the wrap-around subtraction.
  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PW-1:0]     rr_ptr_q,         rr_ptr_d;
  logic [DWIDTH-1:0] write_data_q,     write_data_d;
  logic [AWIDTH-1:0] write_address_q,  write_address_d;
  logic              wakeup_valid_q,   wakeup_valid_d;
  logic [AWIDTH-1:0] wakeup_tag_q,     wakeup_tag_d;

`ifdef WB_STALL_CNT_EN
  logic [N_PORTS-1:0][15:0] stall_count_q, stall_count_d;
  logic [31:0]              grant_count_q, grant_count_d;
`endif

  // ---------------------------------------------------------------------------
  // Arbitration results
  // ---------------------------------------------------------------------------
  logic              grant_found;
  logic [PW-1:0]     grant_idx;
  logic [DWIDTH-1:0] grant_data;
  logic [AWIDTH-1:0] grant_tag;
  logic              do_write;

  // Round-robin scan: first valid port at or after the pointer, wrapping.
  always_comb begin
    logic [PW:0] scan_idx;
    // NOTE: every variable gets a default before any conditional update so no
    // path leaves it unassigned and no latch is inferred.
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      scan_idx = {1'b0, rr_ptr_q} + (PW+1)'(i);
      if (scan_idx >= (PW+1)'(N_PORTS)) begin
        scan_idx = scan_idx - (PW+1)'(N_PORTS);
      end
      if (!grant_found && result_valid_i[scan_idx[PW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx[PW-1:0];
      end
    end
    // No port may be told it was accepted while the block is held in reset.
    if (reset) begin
      grant_found = 1'b0;
    end
  end

  // One-hot ready and selection of the winning port's payload.
  always_comb begin
    result_ready_o = '0;
    if (grant_found) begin
      result_ready_o[grant_idx] = 1'b1;
    end
    grant_data = result_data_i[grant_idx];
    grant_tag  = result_tag_i[grant_idx];
  end

  // Next pointer: one past the winner, holding when nothing is granted.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_found) begin
      if (grant_idx == PW'(N_PORTS - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = grant_idx + PW'(1);
      end
    end
  end

  // Output stage next values. Only an effective write (accepted, not flushed,
  // non-null tag) refreshes the data/tag holding registers, so write_data and
  // wakeup_tag_o always show the last value actually written.
  always_comb begin
    do_write        = grant_found && !flush && (grant_tag != '0);
    write_address_d = do_write ? grant_tag : '0;
    wakeup_valid_d  = do_write;
    write_data_d    = do_write ? grant_data : write_data_q;
    wakeup_tag_d    = do_write ? grant_tag  : wakeup_tag_q;
  end

`ifdef WB_STALL_CNT_EN
  // Stall counters saturate; the grant counter counts every accepted transfer
  // (including null-tag and flushed ones) and wraps naturally.
  always_comb begin
    stall_count_d = stall_count_q;
    for (int k = 0; k < N_PORTS; k++) begin
      if (result_valid_i[k] && !result_ready_o[k] &&
          (stall_count_q[k] != 16'hFFFF)) begin
        stall_count_d[k] = stall_count_q[k] + 16'd1;
      end
    end
    grant_count_d = grant_count_q + (grant_found ? 32'd1 : 32'd0);
  end
`endif

  // Registered stage with asynchronous clear; an in-flight result is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q        <= '0;
      write_data_q    <= '0;
      write_address_q <= '0;
      wakeup_valid_q  <= 1'b0;
      wakeup_tag_q    <= '0;
`ifdef WB_STALL_CNT_EN
      stall_count_q   <= '0;
      grant_count_q   <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values regardless of statement order.
      rr_ptr_q        <= rr_ptr_d;
      write_data_q    <= write_data_d;
      write_address_q <= write_address_d;
      wakeup_valid_q  <= wakeup_valid_d;
      wakeup_tag_q    <= wakeup_tag_d;
`ifdef WB_STALL_CNT_EN
      stall_count_q   <= stall_count_d;
      grant_count_q   <= grant_count_d;
`endif
    end
  end

  assign write_data     = write_data_q;
  assign write_address  = write_address_q;
  assign wakeup_valid_o = wakeup_valid_q;
  assign wakeup_tag_o   = wakeup_tag_q;
`ifdef WB_STALL_CNT_EN
  assign stall_count_o  = stall_count_q;
  assign grant_count_o  = grant_count_q;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// tb_writeback_arbiter
//
// Directed scenarios from the block's behaviour list plus a randomized run
// checked against a cycle-level reference model of the arbitration rules.
// Build with WB_STALL_CNT_EN defined to also exercise the counters.
// -----------------------------------------------------------------------------
module tb_writeback_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 7;

  logic                    clk;
  logic                    reset;
  logic                    flush;
  logic [N-1:0][DW-1:0]    data_drv;
  logic [N-1:0][AW-1:0]    tag_drv;
  logic [N-1:0]            valid_drv;
  logic [N-1:0]            result_ready_o;
  logic [DW-1:0]           write_data;
  logic [AW-1:0]           write_address;
  logic                    wakeup_valid_o;
  logic [AW-1:0]           wakeup_tag_o;
`ifdef WB_STALL_CNT_EN
  logic [N-1:0][15:0]      stall_count_o;
  logic [31:0]             grant_count_o;
`endif

  int passed = 0;
  int total  = 0;

  // Reference model state
  int              m_ptr;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_data;
  logic            m_wv;
  logic [AW-1:0]   m_wtag;
  int              m_stall [N];
  logic [31:0]     m_grants;

  writeback_arbiter #(.N_PORTS(N), .DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .result_data_i  (data_drv),
    .result_tag_i   (tag_drv),
    .result_valid_i (valid_drv),
    .result_ready_o (result_ready_o),
    .write_data     (write_data),
    .write_address  (write_address),
    .wakeup_valid_o (wakeup_valid_o),
    .wakeup_tag_o   (wakeup_tag_o)
`ifdef WB_STALL_CNT_EN
    ,
    .stall_count_o  (stall_count_o),
    .grant_count_o  (grant_count_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, checks %0d/%0d", passed, total);
    $fatal(1);
  end

  // Winner under the round-robin rule, or -1 when nobody is granted.
  function automatic int model_grant(input logic [N-1:0] v, input int p, input logic rst);
    if (rst) return -1;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (p + i) % N;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] r;
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_ptr    = 0;
    m_addr   = '0;
    m_data   = '0;
    m_wv     = 1'b0;
    m_wtag   = '0;
    m_grants = '0;
    for (int k = 0; k < N; k++) m_stall[k] = 0;
  endtask

  // Advance one clock and update the model from the inputs held this cycle.
  task automatic tick();
    int            g;
    logic [AW-1:0] t;
    logic [DW-1:0] d;
    logic          f;
    logic [N-1:0]  v;
    logic          r;
    g = model_grant(valid_drv, m_ptr, reset);
    f = flush;
    v = valid_drv;
    r = reset;
    t = (g >= 0) ? tag_drv[g] : '0;
    d = (g >= 0) ? data_drv[g] : '0;
    @(posedge clk);
    if (!r) begin
      for (int k = 0; k < N; k++) begin
        if (v[k] && g != k && m_stall[k] < 16'hFFFF) m_stall[k]++;
      end
      if (g >= 0) begin
        m_ptr    = (g + 1) % N;
        m_grants = m_grants + 32'd1;
      end
      if (g >= 0 && !f && t != 0) begin
        m_addr = t;
        m_data = d;
        m_wv   = 1'b1;
        m_wtag = t;
      end else begin
        m_addr = '0;
        m_wv   = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    flush     = 1'b0;
    valid_drv = 4'b1111;
    for (int k = 0; k < N; k++) begin
      tag_drv[k]  = AW'(k + 1);
      data_drv[k] = 32'h1000 + k;
    end
    model_reset();
    #3;
    total++;
    if (result_ready_o !== 4'b0000) $display("FAIL reset_ready: got %b expected 0000", result_ready_o);
    else passed++;
    @(posedge clk); #1;
    total++;
    if ({write_address, wakeup_valid_o, wakeup_tag_o, write_data} !== '0)
      $display("FAIL reset_outputs: addr %0d wv %b tag %0d data %h expected all zero",
               write_address, wakeup_valid_o, wakeup_tag_o, write_data);
    else passed++;
    reset     = 1'b0;
    valid_drv = '0;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++;
      if (result_ready_o !== 4'b0000) $display("FAIL idle_ready: cycle %0d got %b expected 0000", c, result_ready_o);
      else passed++;
      tick();
      total++;
      if (write_address !== 7'd0 || wakeup_valid_o !== 1'b0)
        $display("FAIL idle_outputs: cycle %0d addr %0d wv %b expected 0/0", c, write_address, wakeup_valid_o);
      else passed++;
    end
  endtask

  task automatic test_single_port();
    valid_drv   = 4'b0100;
    tag_drv[2]  = 7'd45;
    data_drv[2] = 32'hDEADBEEF;
    #1;
    total++;
    if (result_ready_o !== 4'b0100) $display("FAIL single_ready: got %b expected 0100", result_ready_o);
    else passed++;
    tick();
    valid_drv = '0;
    total++;
    if (write_address !== 7'd45 || write_data !== 32'hDEADBEEF || wakeup_valid_o !== 1'b1 || wakeup_tag_o !== 7'd45)
      $display("FAIL single_write: addr %0d data %h wv %b tag %0d expected 45 deadbeef 1 45",
               write_address, write_data, wakeup_valid_o, wakeup_tag_o);
    else passed++;
    #1;
    tick();
    total++;
    if (write_address !== 7'd0 || wakeup_valid_o !== 1'b0 || write_data !== 32'hDEADBEEF)
      $display("FAIL single_after: addr %0d wv %b data %h expected 0 0 deadbeef",
               write_address, wakeup_valid_o, write_data);
    else passed++;
  endtask

  task automatic test_round_robin();
    int exp_order [6] = '{0, 1, 2, 3, 0, 1};
    // Pointer is 3 after the port-2 grant; one grant to port 3 returns it to 0.
    valid_drv  = 4'b1000;
    tag_drv[3] = 7'd5;
    #1;
    tick();
    for (int k = 0; k < N; k++) tag_drv[k] = AW'(10 + k);
    valid_drv = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      #1;
      total++;
      if (result_ready_o !== onehot(exp_order[c]))
        $display("FAIL rr_ready: cycle %0d got %b expected %b", c, result_ready_o, onehot(exp_order[c]));
      else passed++;
      tick();
      total++;
      if (write_address !== AW'(10 + exp_order[c]))
        $display("FAIL rr_addr: cycle %0d got %0d expected %0d", c, write_address, 10 + exp_order[c]);
      else passed++;
    end
    valid_drv = '0;
  endtask

  task automatic test_tag_zero();
    valid_drv  = 4'b0010;
    tag_drv[1] = 7'd0;
    #1;
    total++;
    if (result_ready_o !== 4'b0010) $display("FAIL tag0_ready: got %b expected 0010", result_ready_o);
    else passed++;
    tick();
    total++;
    if (write_address !== 7'd0 || wakeup_valid_o !== 1'b0)
      $display("FAIL tag0_outputs: addr %0d wv %b expected 0 0", write_address, wakeup_valid_o);
    else passed++;
    // Pointer must now be 2: with ports 1 and 2 valid, port 2 wins.
    valid_drv  = 4'b0110;
    tag_drv[1] = 7'd3;
    tag_drv[2] = 7'd4;
    #1;
    total++;
    if (result_ready_o !== 4'b0100) $display("FAIL tag0_ptr: got %b expected 0100", result_ready_o);
    else passed++;
    tick();
    valid_drv = '0;
    total++;
    if (write_address !== 7'd4) $display("FAIL tag0_next_addr: got %0d expected 4", write_address);
    else passed++;
  endtask

  task automatic test_flush();
    valid_drv  = 4'b1000;
    tag_drv[3] = 7'd20;
    flush      = 1'b1;
    #1;
    total++;
    if (result_ready_o !== 4'b1000) $display("FAIL flush_ready: got %b expected 1000", result_ready_o);
    else passed++;
    tick();
    flush = 1'b0;
    total++;
    if (write_address !== 7'd0 || wakeup_valid_o !== 1'b0)
      $display("FAIL flush_outputs: addr %0d wv %b expected 0 0", write_address, wakeup_valid_o);
    else passed++;
    tag_drv[3] = 7'd21;
    #1;
    tick();
    valid_drv = '0;
    total++;
    if (write_address !== 7'd21 || wakeup_valid_o !== 1'b1)
      $display("FAIL flush_next: addr %0d wv %b expected 21 1", write_address, wakeup_valid_o);
    else passed++;
  endtask

  task automatic test_random();
    int           g;
    logic [N-1:0] pend;
    pend = '0;
    for (int c = 0; c < 300; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!pend[k]) begin
          valid_drv[k] = ($urandom_range(0, 2) != 0);
          tag_drv[k]   = ($urandom_range(0, 7) == 0) ? 7'd0 : AW'($urandom_range(1, 127));
          data_drv[k]  = $urandom;
        end
      end
      flush = ($urandom_range(0, 9) == 0);
      g = model_grant(valid_drv, m_ptr, reset);
      #1;
      total++;
      if (result_ready_o !== onehot(g))
        $display("FAIL rand_ready: cycle %0d got %b expected %b", c, result_ready_o, onehot(g));
      else passed++;
      pend = valid_drv & ~onehot(g);
      tick();
      total++;
      if ({write_address, wakeup_valid_o, wakeup_tag_o, write_data} !== {m_addr, m_wv, m_wtag, m_data})
        $display("FAIL rand_out: cycle %0d got addr %0d wv %b tag %0d data %h expected %0d %b %0d %h",
                 c, write_address, wakeup_valid_o, wakeup_tag_o, write_data, m_addr, m_wv, m_wtag, m_data);
      else passed++;
    end
    valid_drv = '0;
    flush     = 1'b0;
`ifdef WB_STALL_CNT_EN
    for (int k = 0; k < N; k++) begin
      total++;
      if (stall_count_o[k] !== 16'(m_stall[k]))
        $display("FAIL rand_stall: port %0d got %0d expected %0d", k, stall_count_o[k], m_stall[k]);
      else passed++;
    end
    total++;
    if (grant_count_o !== m_grants) $display("FAIL rand_grants: got %0d expected %0d", grant_count_o, m_grants);
    else passed++;
`endif
  endtask

  task automatic test_async_reset();
    valid_drv   = 4'b0001;
    tag_drv[0]  = 7'd33;
    data_drv[0] = 32'hCAFE0001;
    #1;
    tick();
    total++;
    if (write_address !== 7'd33 || wakeup_valid_o !== 1'b1)
      $display("FAIL areset_pre: addr %0d wv %b expected 33 1", write_address, wakeup_valid_o);
    else passed++;
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({write_address, wakeup_valid_o, wakeup_tag_o, write_data, result_ready_o} !== '0)
      $display("FAIL areset_clear: addr %0d wv %b tag %0d data %h ready %b expected all zero",
               write_address, wakeup_valid_o, wakeup_tag_o, write_data, result_ready_o);
    else passed++;
    model_reset();
    @(posedge clk); #1;
    reset     = 1'b0;
    valid_drv = '0;
  endtask

`ifdef WB_STALL_CNT_EN
  task automatic test_stall_counters();
    #1;
    reset = 1'b1;
    #2;
    model_reset();
    reset     = 1'b0;
    valid_drv = 4'b0011;
    tag_drv[0] = 7'd1;
    tag_drv[1] = 7'd2;
    for (int c = 0; c < 6; c++) begin
      #1;
      tick();
    end
    valid_drv = '0;
    total++;
    if (stall_count_o[0] !== 16'd3 || stall_count_o[1] !== 16'd3 || grant_count_o !== 32'd6)
      $display("FAIL stall_counts: stall0 %0d stall1 %0d grants %0d expected 3 3 6",
               stall_count_o[0], stall_count_o[1], grant_count_o);
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_single_port();
    test_round_robin();
    test_tag_zero();
    test_flush();
    test_random();
    test_async_reset();
`ifdef WB_STALL_CNT_EN
    test_stall_counters();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
